// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC engine: rotates (x, y) onto the positive x axis
// and returns the gain-scaled magnitude and atan2(y, x) in Q3.29 radians.
module cordic_vector_iter #(
    parameter int ITER = 16,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W+1:0] mag_out,
    output logic signed [W-1:0] angle_out
);
    localparam int XW = W + 2;
    localparam logic signed [W-1:0] HALF_PI = 32'sh3243F6A9;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    // round(atan(2^-i) * 2^29); beyond i=9 the value is 2^(29-i) after rounding
    function automatic logic signed [W-1:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'sh1921FB54;
            5'd1:    atan_rom = 32'sh0ED63383;
            5'd2:    atan_rom = 32'sh07D6DD7E;
            5'd3:    atan_rom = 32'sh03FAB753;
            5'd4:    atan_rom = 32'sh01FF55BB;
            5'd5:    atan_rom = 32'sh00FFEAAE;
            5'd6:    atan_rom = 32'sh007FFD55;
            5'd7:    atan_rom = 32'sh003FFFAB;
            5'd8:    atan_rom = 32'sh001FFFF5;
            5'd9:    atan_rom = 32'sh000FFFFF;
            5'd30:   atan_rom = '0;
            default: atan_rom = $signed(32'h1 << (5'd29 - idx));
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [4:0]           i_q, i_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [W-1:0]  z_q, z_d;
    logic                 zero_q, zero_d;
    logic signed [XW-1:0] mag_q, mag_d;
    logic signed [W-1:0]  ang_q, ang_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
    logic signed [W-1:0]  atan_i;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        mag_d       = mag_q;
        ang_d       = ang_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        x_ext       = $signed({{2{x_in[W-1]}}, x_in});
        y_ext       = $signed({{2{y_in[W-1]}}, y_in});
        x_sh        = x_q >>> i_q;
        y_sh        = y_q >>> i_q;
        atan_i      = atan_rom(i_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Fold left half-plane vectors into the right half-plane first
                    if (!x_in[W-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_in[W-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = HALF_PI;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -HALF_PI;
                    end
                    zero_d     = (x_in == '0) && (y_in == '0);
                    i_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_ITER;
                end
            end
            S_ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end
                i_d = i_q + 5'd1;
                if (i_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    mag_d       = zero_q ? '0 : x_q;
                    ang_d       = zero_q ? '0 : z_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            ang_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            mag_q       <= mag_d;
            ang_q       <= ang_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mag_out   = mag_q;
    assign angle_out = ang_q;
endmodule

// File: tb/tb_cordic_vector_iter.sv
// Bench for cordic_vector_iter: directed and random vectors compared against a
// floating-point atan2/hypot reference, plus handshake, back-pressure and reset cases.
module tb_cordic_vector_iter;
    localparam int ITER = 16;
    localparam real PI_L = 1686629713.0;
    localparam real SCALE = 536870912.0;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_in, y_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [33:0] mag_out;
    logic signed [31:0] angle_out;

    int  checks = 0;
    int  errors = 0;
    real kgain;

    cordic_vector_iter #(.ITER(ITER), .W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mag_out(mag_out), .angle_out(angle_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare current outputs against K*hypot(x,y) and atan2(y,x) in Q3.29, wrapping the angle error
    task automatic check_vec(input string tag, input longint xv, input longint yv);
        real m_exp, a_exp, d, tol;
        m_exp = kgain * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
        a_exp = $atan2(real'(yv), real'(xv)) * SCALE;
        tol   = 16.0 + m_exp / 1048576.0;
        d     = real'(longint'(mag_out)) - m_exp;
        checks++;
        assert (d <= tol && d >= -tol) else begin
            errors++;
            $error("FAIL %s mag: observed %0d expected %0.1f", tag, longint'(mag_out), m_exp);
        end
        d = real'(angle_out) - a_exp;
        if (d > PI_L) d = d - 2.0 * PI_L;
        else if (d < -PI_L) d = d + 2.0 * PI_L;
        checks++;
        assert (d <= 32768.0 && d >= -32768.0) else begin
            errors++;
            $error("FAIL %s angle: observed %0d expected %0.1f", tag, angle_out, a_exp);
        end
    endtask

    // Present a vector and return at the negedge following its accept edge
    task automatic send(input logic signed [31:0] xv, input logic signed [31:0] yv);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", longint'(in_ready), 1);
        in_valid = 1'b1;
        x_in     = xv;
        y_in     = yv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = $urandom;
        y_in     = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_xfer(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, longint'(out_valid), 0);
        check_eq({tag, "_in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic signed [31:0] rx, ry;
        logic signed [33:0] m_hold;
        logic signed [31:0] a_hold;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_mag", longint'(mag_out), 0);
        check_eq("rst_angle", longint'(angle_out), 0);
        rst = 1'b0;
        @(negedge clk);

        // Positive x axis, latency and single-cycle out_valid
        out_ready = 1'b1;
        send(32'sh00100000, 32'sh0);
        wait_out(lat);
        check_eq("lat_xaxis", lat, ITER + 1);
        check_vec("xaxis", 64'sh00100000, 0);
        check_eq("xaxis_in_ready_busy", longint'(in_ready), 0);
        finish_xfer("xaxis");

        send(32'sh00100000, 32'sh00100000);
        wait_out(lat);
        check_eq("lat_diag", lat, ITER + 1);
        check_vec("diag", 64'sh00100000, 64'sh00100000);
        finish_xfer("diag");

        // Negative x axis must land on +pi, never -pi
        send(-32'sh00100000, 32'sh0);
        wait_out(lat);
        check_vec("neg_x", -64'sh00100000, 0);
        check_eq("neg_x_positive", longint'(angle_out > 0), 1);
        finish_xfer("neg_x");

        send(32'sh0, -32'sh00100000);
        wait_out(lat);
        check_vec("neg_y", 0, -64'sh00100000);
        finish_xfer("neg_y");

        send(32'sh80000000, 32'sh80000000);
        wait_out(lat);
        check_vec("extreme", -64'sh80000000, -64'sh80000000);
        check_eq("extreme_mag_pos", longint'(mag_out > 0), 1);
        finish_xfer("extreme");

        for (int k = 0; k < 10; k++) begin
            rx = $signed($urandom) >>> $urandom_range(0, 12);
            ry = $signed($urandom) >>> $urandom_range(0, 12);
            if (rx < 32'sh10000 && rx > -32'sh10000 && ry < 32'sh10000 && ry > -32'sh10000)
                rx = 32'sh00123456;
            send(rx, ry);
            wait_out(lat);
            check_eq("lat_rand", lat, ITER + 1);
            check_vec("rand", longint'(rx), longint'(ry));
            finish_xfer("rand");
        end

        // Back-pressure: result held, extra in_valid pulses ignored
        out_ready = 1'b0;
        send(32'sh000C0000, -32'sh000A0000);
        wait_out(lat);
        check_vec("bp", 64'sh000C0000, -64'sh000A0000);
        m_hold = mag_out;
        a_hold = angle_out;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            x_in = $urandom;
            y_in = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_valid", longint'(out_valid), 1);
            check_eq("bp_mag", longint'(mag_out), longint'(m_hold));
            check_eq("bp_angle", longint'(angle_out), longint'(a_hold));
            check_eq("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        finish_xfer("bp");
        send(-32'sh00380000, 32'sh00180000);
        wait_out(lat);
        check_eq("lat_after_bp", lat, ITER + 1);
        check_vec("after_bp", -64'sh00380000, 64'sh00180000);
        finish_xfer("after_bp");

        // Reset in the middle of iterating discards the partial result
        send(32'sh00500000, 32'sh00100000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", longint'(out_valid), 0);
        check_eq("midrst_mag", longint'(mag_out), 0);
        check_eq("midrst_angle", longint'(angle_out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_in_ready", longint'(in_ready), 1);
        check_eq("midrst_no_stale", longint'(out_valid), 0);
        send(32'sh0, 32'sh0);
        wait_out(lat);
        check_eq("lat_zero", lat, ITER + 1);
        check_eq("zero_mag", longint'(mag_out), 0);
        check_eq("zero_angle", longint'(angle_out), 0);
        finish_xfer("zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
